fifo_wr_arbiter: RTL

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

---
 rtl/fifo_arb_pkg.sv | 13 +
 rtl/rr_priority_picker.sv | 26 ++
 rtl/fifo_wr_arbiter.sv | 98 +++++++++
 3 files changed

// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared state encoding and index-width helper for the FIFO write arbiter
package fifo_arb_pkg;

  typedef enum logic {
    ARB,
    HOLD
  } state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// rr_priority_picker: combinational first-valid search upward from a pointer, wrapping at N-1
module rr_priority_picker
  import fifo_arb_pkg::*;
#(
  parameter int N = 4,
  parameter int W = idx_w(N)
) (
  input  logic [N-1:0] valid,
  input  logic [W-1:0] ptr,
  output logic         found,
  output logic [W-1:0] idx
);

  // scan offsets from farthest to nearest so the nearest valid requester is the last one written
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (valid[(int'(ptr) + i) % N]) begin
        found = 1'b1;
        idx   = W'((int'(ptr) + i) % N);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter of NUM_REQ requesters onto one FIFO write port;
// define FIFO_WR_ARBITER_BURST_EN to let a requester keep the grant for up to MAX_BURST transfers
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                                clk_i,
  input  logic                                arst_ni,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  req_data_i,
  input  logic [NUM_REQ-1:0]                  req_valid_i,
  output logic [NUM_REQ-1:0]                  req_ready_o,
  output logic [DATA_WIDTH-1:0]               data_out_o,
  output logic                                data_out_valid_o,
  input  logic                                data_out_ready_i,
  output logic [$clog2(NUM_REQ)-1:0]          grant_id_o
);

  localparam int IW = idx_w(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 16 || MAX_BURST < 1) begin : g_bad_param
    $error("fifo_wr_arbiter: parameter out of range");
  end

  state_t          state;
  logic [IW-1:0]   rr_ptr;
  logic [IW-1:0]   hold_idx;
  logic            pick_found;
  logic [IW-1:0]   pick_idx;
  logic            gnt_valid;
  logic [IW-1:0]   gnt_idx;
  logic            xfer;
  logic [IW-1:0]   ptr_inc;

  rr_priority_picker #(
    .N (NUM_REQ),
    .W (IW)
  ) u_picker (
    .valid (req_valid_i),
    .ptr   (rr_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // while holding, the grant is pinned to the latched index; reset blanks every output at once
  assign gnt_idx   = (state == HOLD) ? hold_idx : pick_idx;
  assign gnt_valid = arst_ni && ((state == HOLD) ? req_valid_i[hold_idx] : pick_found);
  assign xfer      = gnt_valid && data_out_ready_i;
  assign ptr_inc   = (gnt_idx == IW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;

  assign data_out_valid_o = gnt_valid;
  assign data_out_o       = gnt_valid ? req_data_i[gnt_idx] : '0;
  assign grant_id_o       = gnt_valid ? gnt_idx : '0;
  assign req_ready_o      = xfer ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << gnt_idx) : '0;

  // a stalled grant enters HOLD; HOLD persists only while that requester stays valid and unaccepted
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state    <= ARB;
      hold_idx <= '0;
    end else begin
      state    <= (gnt_valid && !data_out_ready_i) ? HOLD : ARB;
      hold_idx <= gnt_valid ? gnt_idx : hold_idx;
    end
  end

`ifdef FIFO_WR_ARBITER_BURST_EN
  localparam int CW = idx_w(MAX_BURST + 1);

  logic [CW-1:0] burst_cnt;
  logic [CW-1:0] run_len;
  logic          keep;

  // burst_cnt is only meaningful while rr_ptr still sits on the requester that earned it
  assign run_len = ((gnt_idx == rr_ptr) ? burst_cnt : '0) + 1'b1;
  assign keep    = (int'(run_len) < MAX_BURST) && req_valid_i[gnt_idx];

  // on each transfer either stay on the granted requester to extend its burst or move past it
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      rr_ptr    <= '0;
      burst_cnt <= '0;
    end else if (xfer) begin
      rr_ptr    <= keep ? gnt_idx : ptr_inc;
      burst_cnt <= keep ? run_len : '0;
    end
  end
`else
  // every transfer moves priority to the requester after the one just served
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) rr_ptr <= '0;
    else if (xfer) rr_ptr <= ptr_inc;
  end
`endif

endmodule
